// File: rtl/enc_pkg.sv
// Shared types and helpers for the bitmask encoder.
// State encoding plus a one-hot test used by strict mode.
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        EMIT_LAST
    } state_t;

    // Widest vector the one-hot helper is sized for.
    localparam int ENC_MAX_W = 256;

    function automatic logic is_onehot(input logic [ENC_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - ENC_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/bitmask_encoder_prio_pick.sv
// Combinational priority picker: first set bit by priority order,
// its index, and the input vector with that bit cleared.
module prio_pick #(
    parameter  int WIDTH     = 8,
    parameter  int MSB_FIRST = 0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [IDX_W-1:0] idx,
    output logic             found,
    output logic [WIDTH-1:0] rest
);

    // Scan in priority order, keep the first hit, then clear it.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && in[(MSB_FIRST != 0) ? (WIDTH - 1 - i) : i]) begin
                idx   = IDX_W'((MSB_FIRST != 0) ? (WIDTH - 1 - i) : i);
                found = 1'b1;
            end
        end
        rest = in;
        if (found) begin
            rest[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/bitmask_encoder.sv
// Handshaked bitmask encoder: strict one-hot check or scan of all
// set bits, one registered index beat per output handshake.
module bitmask_encoder
    import enc_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MSB_FIRST = 0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_seq,
    output logic             out_last,
    output logic             out_err
);

    state_t             r_state;
    state_t             w_state_nx;
    logic [WIDTH-1:0]   r_pend;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W:0]     r_seq;
    logic               r_last;
    logic               r_err;

    logic               w_accept;
    logic               w_load_acc;
    logic               w_load_nxt;
    logic [WIDTH-1:0]   w_pick_in;
    logic [IDX_W-1:0]   w_idx;
    logic               w_found;
    logic [WIDTH-1:0]   w_rest;
    logic               w_first_last;

    assign in_ready  = rst_n &
                       ((r_state == IDLE) |
                        ((r_state == EMIT_LAST) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state != IDLE);
    assign out_idx   = r_idx;
    assign out_seq   = r_seq;
    assign out_last  = r_last;
    assign out_err   = r_err;

    // One picker serves both paths; in EMIT no vector can be accepted.
    assign w_pick_in    = (r_state == EMIT) ? r_pend : in_data;
    assign w_first_last = in_mode | (w_rest == '0);

    prio_pick #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_pick (
        .in    (w_pick_in),
        .idx   (w_idx),
        .found (w_found),
        .rest  (w_rest)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and datapath load enables.
    always_comb begin
        w_state_nx = r_state;
        w_load_acc = 1'b0;
        w_load_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load_acc = 1'b1;
                    w_state_nx = w_first_last ? EMIT_LAST : EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_load_nxt = 1'b1;
                    if (w_rest == '0) begin
                        w_state_nx = EMIT_LAST;
                    end
                end
            end
            EMIT_LAST: begin
                if (w_accept) begin
                    w_load_acc = 1'b1;
                    w_state_nx = w_first_last ? EMIT_LAST : EMIT;
                end else if (out_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Output beat and pending-mask registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_idx  <= '0;
            r_seq  <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_load_acc) begin
            r_idx  <= w_idx;
            r_seq  <= '0;
            r_pend <= in_mode ? '0 : w_rest;
            r_last <= w_first_last;
            r_err  <= in_mode ? !is_onehot(ENC_MAX_W'(in_data))
                              : !w_found;
        end else if (w_load_nxt) begin
            r_idx  <= w_idx;
            r_pend <= w_rest;
            r_seq  <= r_seq + (IDX_W + 1)'(1);
            r_last <= (w_rest == '0);
        end
    end

endmodule

// File: doc/bitmask_encoder.md
# bitmask_encoder

Parametrised, handshaked successor to the 8:3 one-hot encoder. It accepts a WIDTH-bit vector and emits bit indices on a registered valid/ready output. In strict mode it emits one index per vector and flags any input that is not one-hot. In scan mode it walks every set bit in priority order, one index per beat. It sits between request/flag producers and index-consuming logic (arbiters, interrupt dispatch).

## Interface
- WIDTH, 8, input vector width; legal range ≥2.
- IDX_W, $clog2(WIDTH), index width; derived, not overridden.
- MSB_FIRST, 0, priority order: 0 = lowest set bit first, 1 = highest set bit first.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_data  input  WIDTH  vector to encode.
- in_mode  input  1  0 = scan (all set bits), 1 = strict one-hot.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts beat.
- out_idx  output  IDX_W  encoded bit index.
- out_seq  output  IDX_W+1  beat number within the current vector, starting at 0.
- out_last  output  1  final beat of the current vector.
- out_err  output  1  vector error: zero input in either mode, or multi-hot in strict mode.

## Operation
- States: IDLE (no beat held), EMIT (beat held, more bits pending), EMIT_LAST (final beat held).
- in_ready = rst_n & (state==IDLE | (state==EMIT_LAST & out_ready)).
- Accept (in_valid & in_ready): latch the first-priority set bit into out_idx and set out_seq=0.
  - pending mask = in_data with that bit cleared; in strict mode pending is forced to 0.
- Scan, non-zero vector: err=0; go to EMIT if pending≠0, else EMIT_LAST.
- Strict mode: out_idx = first-priority set bit, out_last=1, go to EMIT_LAST; err=1 iff popcount(in_data)≠1.
- Zero vector (either mode): single beat with out_idx=0, out_err=1, out_last=1.
- EMIT & out_ready: load the next priority bit from pending, clear it, increment out_seq; go to EMIT_LAST when the remaining pending becomes 0.
- EMIT_LAST & out_ready: go to IDLE, or reload directly if a new vector is accepted in the same cycle.
- out_valid = (state≠IDLE). Output registers hold while out_valid & !out_ready; in_data changes are ignored after acceptance.
- out_err is constant across all beats of one vector.

## Timing
- Reset (rst_n low at an edge) clears state to IDLE, pending=0, out_valid=0, out_idx=0, out_seq=0, out_last=0, out_err=0. in_ready=0 while rst_n is low.
- Reset mid-scan discards pending bits; no partial beat follows.
- Latency: vector accepted at edge N → out_valid at N+1 (registered, no combinational in→out path).
- Throughput:
  - strict mode sustains 1 vector/cycle under continuous out_ready;
  - scan mode yields K beats for K set bits, and the next vector is accepted in the cycle the last beat handshakes.
- Back-pressure: all outputs stable while out_valid & !out_ready.
- Full-vector boundary: all WIDTH bits set → WIDTH beats; out_seq runs 0..WIDTH-1.

## Structure
- Package enc_pkg: state enum (IDLE, EMIT, EMIT_LAST) and a popcount-equals-one helper function.
- Sub-module prio_pick (combinational, parametrised by WIDTH and MSB_FIRST):
  - input vector in;
  - outputs idx, found, and vector with the picked bit cleared.
- Instantiated once, shared between the accept path and the EMIT path through a mux on its input.
- Top holds the FSM, the pending register and the output registers.

## Test plan
- WIDTH=8, MSB_FIRST=0, scan, in_data=8'b1010_0100, out_ready=1 → beats idx 2,5,7; seq 0,1,2; last on third; err=0; out_valid first at N+1.
- Strict mode:
  - 8'b0001_0000 → one beat, idx=4, last=1, err=0;
  - 8'b0001_0010 → idx=1, err=1;
  - 8'h00 → idx=0, err=1.
- MSB_FIRST=1, scan, 8'b1010_0100 → idx 7,5,2.
- Scan 8'hFF with out_ready toggling 1,0,1,0… → 8 beats idx 0..7, each held stable while stalled; in_ready stays 0 until beat 7 handshakes.
- Back-to-back strict vectors 8'h01, 8'h80, 8'h04 with in_valid held and out_ready=1 → idx 0,7,2 on consecutive cycles, in_ready=1 throughout.
- Scan 8'b1111_0000, assert rst_n=0 after beat idx=5 handshakes → next edge out_valid=0, all outputs zero; after release, a new vector 8'h02 yields idx=1 only.
